// File: rtl/sd_pkg.sv
// Shared definitions for the SD SPI-mode data-block engine: FSM states,
// result codes, token values and block geometry.
package sd_pkg;

  typedef enum logic [3:0] {
    IDLE, W_TOKEN, W_FETCH, W_DATA, W_CRCH, W_CRCL, W_RESP, W_BUSY,
    R_POLL, R_DATA, R_CRCH, R_CRCL, FINISH
  } state_t;

  typedef enum logic [2:0] {
    ST_OK      = 3'd0,
    ST_TOKEN_TO = 3'd1,
    ST_CRC_ERR = 3'd2,
    ST_WR_REJ  = 3'd3,
    ST_BUSY_TO = 3'd4
  } status_t;

  localparam logic [7:0] TOK_START = 8'hFE;
  localparam logic [7:0] RESP_OK   = 8'h05;
  localparam logic [7:0] RESP_MASK = 8'h1F;
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  localparam int         BLOCK_LEN = 512;
  localparam logic [8:0] LAST_IDX  = 9'(BLOCK_LEN - 1);

endpackage

// File: rtl/spi_byte_xfer.sv
// One-byte handshake onto the SPI byte shifter: registers the request into a
// start pulse and reports completion once the shifter has gone idle again.
module spi_byte_xfer
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       xfer_req,
  input  logic       xfer_dir,
  input  logic [7:0] tx_byte,
  output logic       xfer_ready,
  output logic       xfer_done,
  output logic [7:0] rx_byte,
  output logic       sh_start_write,
  output logic       sh_start_read,
  output logic [7:0] sh_shift_in,
  input  logic [7:0] sh_shift_out,
  input  logic       sh_busy
);

  localparam int STAGES = 2;

  // [0] start cycle, [1] busy rising, [STAGES] waiting for busy to drop
  logic [STAGES:0] vld_pipe;
  logic            dir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      dir_q       <= 1'b0;
      sh_shift_in <= FILL_BYTE;
    end else begin
      vld_pipe[0]      <= xfer_req;
      vld_pipe[1]      <= vld_pipe[0];
      vld_pipe[STAGES] <= vld_pipe[1] | (vld_pipe[STAGES] & sh_busy);
      if (xfer_req) begin
        dir_q       <= xfer_dir;
        sh_shift_in <= xfer_dir ? tx_byte : FILL_BYTE;
      end
    end
  end

  assign sh_start_write = vld_pipe[0] &  dir_q;
  assign sh_start_read  = vld_pipe[0] & ~dir_q;
  assign xfer_done      = vld_pipe[STAGES] & ~sh_busy;
  assign xfer_ready     = ~|vld_pipe;
  assign rx_byte        = sh_shift_out;

endmodule

// File: rtl/sd_block_engine.sv
// Sequences one 512-byte SD block read or write in SPI mode: tokens, data,
// CRC16, data-response and busy wait, using the byte-transfer handshake.
module sd_block_engine
  import sd_pkg::*;
#(
  parameter logic [15:0] TOKEN_POLLS = 16'd4095,
  parameter logic [19:0] BUSY_POLLS  = 20'd262143
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_start,
  input  logic        cmd_dir,
  output logic        done,
  output logic [2:0]  status,
  output logic        active,
  output logic [8:0]  buf_addr,
  output logic [7:0]  buf_wdata,
  output logic        buf_we,
  input  logic [7:0]  buf_rdata,
  output logic        sh_start_write,
  output logic        sh_start_read,
  output logic [7:0]  sh_shift_in,
  input  logic [7:0]  sh_shift_out,
  input  logic        sh_busy,
  output logic        sh_crc_reset,
  output logic        sh_crc_source,
  input  logic [15:0] sh_crc_out
);

  state_t      state, state_nxt;
  logic [2:0]  status_nxt;
  logic [8:0]  byte_cnt;
  logic [19:0] poll_cnt;
  logic [15:0] crc_hold;
  logic        crc_src_q, crc_rst_q;

  logic        xfer_req, xfer_dir, xfer_ready, xfer_done;
  logic [7:0]  tx_byte, rx_byte;
  logic        byte_state, last_byte, tok_last, busy_last;

  assign byte_state = state inside {W_TOKEN, W_DATA, W_CRCH, W_CRCL, W_RESP,
                                    W_BUSY, R_POLL, R_DATA, R_CRCH, R_CRCL};
  assign xfer_dir   = state inside {W_TOKEN, W_DATA, W_CRCH, W_CRCL};
  assign xfer_req   = byte_state & xfer_ready;
  assign last_byte  = (byte_cnt == LAST_IDX);
  // poll_cnt holds bytes already rejected, so the current one is the limit-th
  assign tok_last   = (poll_cnt == ({4'd0, TOKEN_POLLS} - 20'd1));
  assign busy_last  = (poll_cnt == (BUSY_POLLS - 20'd1));

  spi_byte_xfer u_xfer (
    .clk           (clk),
    .rst_n         (rst_n),
    .xfer_req      (xfer_req),
    .xfer_dir      (xfer_dir),
    .tx_byte       (tx_byte),
    .xfer_ready    (xfer_ready),
    .xfer_done     (xfer_done),
    .rx_byte       (rx_byte),
    .sh_start_write(sh_start_write),
    .sh_start_read (sh_start_read),
    .sh_shift_in   (sh_shift_in),
    .sh_shift_out  (sh_shift_out),
    .sh_busy       (sh_busy)
  );

  always_comb begin
    state_nxt  = state;
    status_nxt = status;
    tx_byte    = FILL_BYTE;
    case (state)
      IDLE:    if (cmd_start) begin
                 state_nxt  = cmd_dir ? W_TOKEN : R_POLL;
                 status_nxt = ST_OK;
               end
      W_TOKEN: begin
                 tx_byte = TOK_START;
                 if (xfer_done) state_nxt = W_FETCH;
               end
      W_FETCH: state_nxt = W_DATA;
      W_DATA:  begin
                 tx_byte = buf_rdata;
                 if (xfer_done) state_nxt = last_byte ? W_CRCH : W_FETCH;
               end
      W_CRCH:  begin
                 tx_byte = crc_hold[15:8];
                 if (xfer_done) state_nxt = W_CRCL;
               end
      W_CRCL:  begin
                 tx_byte = crc_hold[7:0];
                 if (xfer_done) state_nxt = W_RESP;
               end
      W_RESP:  if (xfer_done) begin
                 if ((rx_byte & RESP_MASK) != RESP_OK) begin
                   state_nxt  = FINISH;
                   status_nxt = ST_WR_REJ;
                 end else state_nxt = W_BUSY;
               end
      W_BUSY:  if (xfer_done) begin
                 if (rx_byte != 8'h00) begin
                   state_nxt  = FINISH;
                   status_nxt = ST_OK;
                 end else if (busy_last) begin
                   state_nxt  = FINISH;
                   status_nxt = ST_BUSY_TO;
                 end
               end
      R_POLL:  if (xfer_done) begin
                 if (rx_byte == TOK_START) state_nxt = R_DATA;
                 else if (tok_last) begin
                   state_nxt  = FINISH;
                   status_nxt = ST_TOKEN_TO;
                 end
               end
      R_DATA:  if (xfer_done && last_byte) state_nxt = R_CRCH;
      R_CRCH:  if (xfer_done) state_nxt = R_CRCL;
      // both CRC bytes have passed through the CRC, so a clean block leaves zero
      R_CRCL:  if (xfer_done) begin
                 state_nxt  = FINISH;
                 status_nxt = (sh_crc_out == 16'h0000) ? ST_OK : ST_CRC_ERR;
               end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      status    <= ST_OK;
      byte_cnt  <= '0;
      poll_cnt  <= '0;
      crc_hold  <= '0;
      crc_src_q <= 1'b1;
      crc_rst_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      status    <= status_nxt;
      // fires the cycle after a byte completes, before the next start is issued
      crc_rst_q <= xfer_done & ((state == W_TOKEN) |
                                ((state == R_POLL) & (rx_byte == TOK_START)));
      if (state == IDLE && cmd_start) begin
        byte_cnt  <= '0;
        poll_cnt  <= '0;
        crc_src_q <= ~cmd_dir;
      end
      if (state == FINISH) crc_src_q <= 1'b1;
      if (xfer_done) begin
        case (state)
          W_DATA: begin
            byte_cnt <= byte_cnt + 9'd1;
            if (last_byte) crc_hold <= sh_crc_out;
          end
          R_DATA:         byte_cnt <= byte_cnt + 9'd1;
          W_RESP:         poll_cnt <= '0;
          W_BUSY, R_POLL: if (!(tok_last && busy_last)) poll_cnt <= poll_cnt + 20'd1;
          default: ;
        endcase
      end
    end
  end

  assign done          = (state == FINISH);
  assign active        = (state != IDLE);
  assign buf_addr      = byte_cnt;
  assign buf_we        = (state == R_DATA) & xfer_done;
  assign buf_wdata     = buf_we ? rx_byte : 8'h00;
  assign sh_crc_reset  = crc_rst_q;
  assign sh_crc_source = crc_src_q;

endmodule

// File: tb/tb_sd_block_engine.sv
// Randomized bench for sd_block_engine: shifter/card/buffer models plus a
// block-level reference that derives bytes on the wire, buffer writes and status.
module tb_sd_block_engine;

  localparam logic [15:0] TOK_P = 16'd8;
  localparam logic [19:0] BSY_P = 20'd8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_start = 1'b0, cmd_dir = 1'b0;
  logic        done, active, buf_we;
  logic [2:0]  status;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_wdata;
  logic [7:0]  buf_rdata = 8'h00;
  logic        sh_start_write, sh_start_read, sh_crc_reset, sh_crc_source;
  logic [7:0]  sh_shift_in;
  logic [7:0]  sh_shift_out = 8'h00;
  logic        sh_busy = 1'b0;
  logic [15:0] sh_crc_out = 16'h0000;

  sd_block_engine #(.TOKEN_POLLS(TOK_P), .BUSY_POLLS(BSY_P)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_dir(cmd_dir),
    .done(done), .status(status), .active(active),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we), .buf_rdata(buf_rdata),
    .sh_start_write(sh_start_write), .sh_start_read(sh_start_read),
    .sh_shift_in(sh_shift_in), .sh_shift_out(sh_shift_out), .sh_busy(sh_busy),
    .sh_crc_reset(sh_crc_reset), .sh_crc_source(sh_crc_source), .sh_crc_out(sh_crc_out)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc16_upd(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in ^ {d, 8'h00};
    for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  // stimulus: buffer contents and the byte stream the card puts on MISO
  logic [7:0] mem [512];
  logic [7:0] script [$];
  logic [7:0] dflt = 8'hFF;

  function automatic logic [7:0] sb(input int i);
    return (i < script.size()) ? script[i] : dflt;
  endfunction

  // shifter + card model
  logic [8:0]  mosi_log [$];
  logic [16:0] we_log [$];
  int          card_idx = 0, viol = 0, done_cnt = 0, bcnt = 0;
  logic        just_fell = 1'b0, clr_req = 1'b0;
  logic [7:0]  cur_mosi = 8'h00, cur_miso = 8'h00;

  always @(posedge clk) begin
    just_fell <= 1'b0;
    if (sh_crc_reset) begin
      if (sh_busy) viol <= viol + 1;
      sh_crc_out <= 16'h0000;
    end
    if (sh_start_write || sh_start_read) begin
      if (sh_busy || just_fell || (sh_start_write && sh_start_read)) viol <= viol + 1;
      mosi_log.push_back({sh_start_write, sh_shift_in});
      cur_mosi <= sh_shift_in;
      cur_miso <= sb(card_idx);
      card_idx <= card_idx + 1;
      sh_busy  <= 1'b1;
      bcnt     <= int'($urandom_range(0, 2));
    end else if (sh_busy) begin
      if (bcnt == 0) begin
        sh_busy      <= 1'b0;
        just_fell    <= 1'b1;
        sh_shift_out <= cur_miso;
        sh_crc_out   <= crc16_upd(sh_crc_out, sh_crc_source ? cur_miso : cur_mosi);
      end else bcnt <= bcnt - 1;
    end
    if (clr_req) begin
      card_idx <= 0;
      viol     <= 0;
      mosi_log.delete();
    end
  end

  always @(posedge clk) buf_rdata <= mem[buf_addr];

  always @(negedge clk) begin
    if (clr_req) begin
      we_log.delete();
      done_cnt <= 0;
    end else begin
      if (buf_we) we_log.push_back({buf_addr, buf_wdata});
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  // reference: what a correct block engine puts on the wire for mem/script
  logic [8:0]  exp_mosi [$];
  logic [16:0] exp_we [$];

  task automatic model(input logic dir, output logic [2:0] st);
    logic [15:0] c;
    logic [7:0]  d;
    int          nrd, p;
    bit          found;
    exp_mosi.delete();
    exp_we.delete();
    nrd = 0;
    if (dir) begin
      exp_mosi.push_back({1'b1, 8'hFE});
      c = 16'h0;
      for (int i = 0; i < 512; i++) begin
        exp_mosi.push_back({1'b1, mem[i]});
        c = crc16_upd(c, mem[i]);
      end
      exp_mosi.push_back({1'b1, c[15:8]});
      exp_mosi.push_back({1'b1, c[7:0]});
      p = 515;
      nrd = 1;
      if ((sb(p) & 8'h1F) != 8'h05) st = 3'd3;
      else begin
        st = 3'd4;
        for (int k = 0; k < int'(BSY_P); k++)
          if (st == 3'd4) begin
            nrd++;
            if (sb(p + 1 + k) != 8'h00) st = 3'd0;
          end
      end
    end else begin
      found = 0;
      p = 0;
      for (int k = 0; k < int'(TOK_P); k++)
        if (!found) begin
          nrd++;
          if (sb(k) == 8'hFE) begin found = 1; p = k + 1; end
        end
      if (!found) st = 3'd1;
      else begin
        c = 16'h0;
        for (int i = 0; i < 514; i++) begin
          d = sb(p + i);
          c = crc16_upd(c, d);
          if (i < 512) exp_we.push_back({9'(i), d});
        end
        nrd += 514;
        st = (c == 16'h0) ? 3'd0 : 3'd2;
      end
    end
    for (int i = 0; i < nrd; i++) exp_mosi.push_back({1'b0, 8'hFF});
  endtask

  task automatic build_write(input bit pattern, input logic [7:0] resp, input int zeros, input bit term);
    for (int i = 0; i < 512; i++) mem[i] = pattern ? 8'(i) : 8'($urandom);
    script.delete();
    for (int i = 0; i < 515; i++) script.push_back(8'($urandom));
    script.push_back(resp);
    for (int i = 0; i < zeros; i++) script.push_back(8'h00);
    if (term) script.push_back(8'h01 | 8'($urandom));
    dflt = 8'h00;
  endtask

  task automatic build_read(input int lead, input bit rnd, input bit corrupt);
    logic [15:0] c;
    logic [7:0]  d;
    script.delete();
    for (int i = 0; i < lead; i++) script.push_back(rnd ? (8'($urandom) & 8'h7F) : 8'hFF);
    script.push_back(8'hFE);
    c = 16'h0;
    for (int i = 0; i < 512; i++) begin
      d = rnd ? 8'($urandom) : 8'hA5;
      script.push_back(d);
      c = crc16_upd(c, d);
    end
    script.push_back(c[15:8]);
    script.push_back(c[7:0] ^ (corrupt ? 8'hFF : 8'h00));
    dflt = 8'hFF;
  endtask

  task automatic clear_logs();
    clr_req = 1'b1;
    @(posedge clk);
    #1 clr_req = 1'b0;
  endtask

  task automatic run_check(input string nm, input logic dir, input bit inject);
    logic [2:0] exp_st, got_st;
    bit         ok;
    int         n, bad;
    model(dir, exp_st);
    clear_logs();
    cmd_dir   = dir;
    cmd_start = 1'b1;
    @(posedge clk);
    #1 cmd_start = 1'b0;
    ok = 0; n = 0; got_st = 3'd7;
    while (!ok && n < 20000) begin
      @(negedge clk);
      n++;
      if (inject && n == 40) begin cmd_start = 1'b1; cmd_dir = ~dir; end
      else if (inject && n == 41) cmd_start = 1'b0;
      if (done) begin
        ok = 1;
        got_st = status;
        chk({nm, "_active_at_done"}, 32'(active), 32'd1);
      end
    end
    cmd_start = 1'b0;
    chk({nm, "_done_seen"}, 32'(ok), 32'd1);
    chk({nm, "_status"}, 32'(got_st), 32'(exp_st));
    repeat (3) @(negedge clk);
    chk({nm, "_status_held"}, 32'(status), 32'(exp_st));
    chk({nm, "_active_after"}, 32'(active), 32'd0);
    chk({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({nm, "_protocol_viol"}, 32'(viol), 32'd0);
    chk({nm, "_mosi_len"}, 32'(mosi_log.size()), 32'(exp_mosi.size()));
    bad = 0;
    for (int i = 0; i < exp_mosi.size() && i < mosi_log.size(); i++)
      if (mosi_log[i] !== exp_mosi[i]) bad++;
    chk({nm, "_mosi_bad_bytes"}, 32'(bad), 32'd0);
    chk({nm, "_we_len"}, 32'(we_log.size()), 32'(exp_we.size()));
    bad = 0;
    for (int i = 0; i < exp_we.size() && i < we_log.size(); i++)
      if (we_log[i] !== exp_we[i]) bad++;
    chk({nm, "_we_bad"}, 32'(bad), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_write();
    int n;
    build_write(1'b0, 8'h05, 0, 1'b1);
    clear_logs();
    cmd_dir   = 1'b1;
    cmd_start = 1'b1;
    @(posedge clk);
    #1 cmd_start = 1'b0;
    n = 0;
    while (mosi_log.size() < 102 && n < 5000) begin @(posedge clk); n++; end
    chk("rst_reached_byte100", 32'(mosi_log.size() >= 102), 32'd1);
    @(negedge clk);
    chk("rst_active_before", 32'(active), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_buf_addr", 32'(buf_addr), 32'd0);
    chk("rst_shift_in", 32'(sh_shift_in), 32'hFF);
    chk("rst_crc_src", 32'(sh_crc_source), 32'd1);
    chk("rst_strobes", 32'({sh_start_write, sh_start_read, sh_crc_reset, buf_we}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    chk("rst_stays_idle", 32'(active), 32'd0);
  endtask

  initial begin
    logic dir;
    repeat (3) @(posedge clk);
    #1;
    chk("init_outputs", 32'({done, active, buf_we, sh_start_write, sh_start_read, sh_crc_reset}), 32'd0);
    chk("init_status", 32'(status), 32'd0);
    chk("init_addr_wdata", 32'({buf_addr, buf_wdata}), 32'd0);
    chk("init_shift_in", 32'(sh_shift_in), 32'hFF);
    chk("init_crc_src", 32'(sh_crc_source), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    build_write(1'b1, 8'h05, 2, 1'b1);
    run_check("wr_ok", 1'b1, 1'b0);
    build_write(1'b1, 8'h0B, 0, 1'b1);
    run_check("wr_rej", 1'b1, 1'b0);
    build_read(3, 1'b0, 1'b0);
    run_check("rd_ok", 1'b0, 1'b1);
    build_read(3, 1'b0, 1'b1);
    run_check("rd_crc_err", 1'b0, 1'b0);
    script.delete();
    dflt = 8'hFF;
    run_check("tok_to", 1'b0, 1'b0);
    build_write(1'b0, 8'h05, 0, 1'b0);
    run_check("busy_to", 1'b1, 1'b0);

    for (int t = 0; t < 4; t++) begin
      dir = 1'($urandom);
      if (dir)
        build_write(1'b0, ($urandom_range(0, 3) != 0) ? {3'($urandom), 5'h05} : 8'h0D,
                    int'($urandom_range(0, 9)), 1'b1);
      else
        build_read(int'($urandom_range(0, 9)), 1'b1, ($urandom_range(0, 2) == 0));
      run_check($sformatf("rand%0d", t), dir, 1'b0);
    end

    reset_mid_write();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
